pe_core_multi: RTL and testbench
================================

Name: pe_core_multi

Overview:
Parametrised successor to the single-lane PE core. It is a LANES-wide SIMD ALU/MAC and is fully pipelined, with valid/ready handshakes on both input and output. It accepts one instruction per cycle and broadcasts the decoded op across all lanes. Results return in order, tagged with the destination register index so the regfile writeback can be driven directly.

Parameters:
- LANES, 4, number of parallel lanes (1..16).
- DATA_W, 32, lane width in bits (8..32).
- CNT_W, 16, width of the retired-op counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction/operand beat valid.
- in_ready  out  1  core can accept a beat.
- instr  in  32  instruction word:
  - [26:20] major opcode.
  - [19:15] func.
  - [14:10] rs1.
  - [9:5] rs2.
  - [4:0] rd.
  - [31:27] ignored.
- op1  in  LANES*DATA_W  lane operands A; lane i occupies [i*DATA_W +: DATA_W].
- op2  in  LANES*DATA_W  lane operands B.
- op3  in  LANES*DATA_W  lane accumulators, used by MAC only.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  LANES*DATA_W  lane results.
- out_rd  out  5  rd field of the producing instruction.
- out_err  out  1  illegal opcode flag; out_data is 0 when set.
- busy  out  1  any pipeline stage holds a valid entry.
- retired  out  CNT_W  count of result beats accepted downstream.

Behaviour:
Reset:
- Asynchronous, active-high; all stage valids are cleared.
- Output reset values: out_valid=0, out_data=0, out_rd=0, out_err=0, busy=0, retired=0.
- in_ready=1 while rst is deasserted and the pipe is empty.

Handshake:
- An input beat transfers on in_valid&&in_ready.
- An output beat transfers on out_valid&&out_ready.
- out_data, out_rd and out_err are held stable while out_valid&&!out_ready.

Pipeline:
- S1 registers the decoded op, rd and operands.
- S2 registers the lane results and drives the outputs.
- Latency: the result appears 2 cycles after input acceptance when out_ready is held high.
- Throughput: 1 beat per cycle.

Stall rules:
- s2_adv = !s2_valid || out_ready.
- s1_adv = !s1_valid || s2_adv.
- in_ready = s1_adv, which is combinational from out_ready; no combinational path runs from in_valid to in_ready.
- A stalled S2 holds its contents. S1 holds if it is full and cannot advance.
- An accept into S1 and a drain from S2 in the same cycle are legal and must not lose or duplicate beats.

Decode (major/func):
- 0x01 (ALU):
  - 1 ADD
  - 2 SUB (op1-op2)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SHL by op2[log2(DATA_W)-1:0]
  - 7 SHR logical, same shift field
  - 8 MIN signed
  - 9 MAX signed
- 0x02 (MUL):
  - 1 MUL: low DATA_W bits of the signed product.
  - 2 MAC: op1*op2+op3, computed on the full product, then reduced to DATA_W.
- Any other major/func combination: out_err=1 and out_data=0. It still occupies a slot and retires normally.

Arithmetic:
- Two's complement.
- Each lane is independent with no inter-lane carry.

retired counter:
- Increments on each output transfer.
- Wraps modulo 2^CNT_W.

busy:
- busy = s1_valid || s2_valid.

Reset mid-operation:
- All in-flight beats are dropped with no output transfer.
- retired is cleared.

Optional Feature:
- Macro: PE_CORE_SAT_EN.
- Defined: ADD, SUB and MAC clamp per lane to signed [-2^(DATA_W-1), 2^(DATA_W-1)-1]. An extra output bit out_sat (1 bit) is the OR across lanes of the clamp events for the beat; it is held with the beat and resets to 0.
- Undefined: all results wrap modulo 2^DATA_W and the out_sat port is absent.

Decomposition:
- Package pe_core_pkg holds:
  - Major-opcode localparams: OP_ALU=7'h01, OP_MUL=7'h02.
  - Func localparams: F_ADD..F_MAX, F_MUL, F_MAC.
  - Instruction field bit positions.
  - The decoded-op enum type.
- Sub-module pe_lane_alu: a combinational single-lane datapath (DATA_W, op enum → result, sat flag), instantiated LANES times by generate.
- The pipeline, handshake and counter live in the top-level module.

Test Plan:
1. Reset, then LANES=4, DATA_W=32, ADD, rd=5, op1 lanes={10,50,-1,7}, op2 lanes={20,25,1,0} → out_data={30,75,0,7}, out_rd=5, out_err=0, 2 cycles after accept; retired=1.
2. Back-to-back SUB, MUL, MAC with out_ready=1 → three results on 3 consecutive cycles, in order. Check MAC with op1=3, op2=4, op3=5 → 17.
3. Hold out_ready=0 while issuing 3 beats → in_ready drops after 2 accepts and outputs stay stable. Raise out_ready → all 3 drain in order with none lost.
4. Instruction with major=0x05 → out_err=1, out_data=0, retired increments.
5. ADD of 0x7FFFFFFF+1 → 0x80000000 without PE_CORE_SAT_EN; 0x7FFFFFFF with out_sat=1 when defined.
6. Assert rst with 2 beats in flight → out_valid=0, busy=0, retired=0 immediately. Verify no spurious output after reset release.

Source files
------------

// File: rtl/pe_core_pkg.sv
// Shared opcode/func encodings, instruction field layout and decoded-op type
// for the multi-lane PE core.
package pe_core_pkg;

  localparam logic [6:0] OP_ALU = 7'h01;
  localparam logic [6:0] OP_MUL = 7'h02;

  localparam logic [4:0] F_ADD = 5'd1;
  localparam logic [4:0] F_SUB = 5'd2;
  localparam logic [4:0] F_AND = 5'd3;
  localparam logic [4:0] F_OR  = 5'd4;
  localparam logic [4:0] F_XOR = 5'd5;
  localparam logic [4:0] F_SHL = 5'd6;
  localparam logic [4:0] F_SHR = 5'd7;
  localparam logic [4:0] F_MIN = 5'd8;
  localparam logic [4:0] F_MAX = 5'd9;
  localparam logic [4:0] F_MUL = 5'd1;
  localparam logic [4:0] F_MAC = 5'd2;

  localparam int unsigned MAJ_LSB  = 20;
  localparam int unsigned MAJ_W    = 7;
  localparam int unsigned FUNC_LSB = 15;
  localparam int unsigned FUNC_W   = 5;
  localparam int unsigned RS1_LSB  = 10;
  localparam int unsigned RS2_LSB  = 5;
  localparam int unsigned RD_LSB   = 0;
  localparam int unsigned REG_W    = 5;

  typedef enum logic [3:0] {
    OPC_ILL,
    OPC_ADD,
    OPC_SUB,
    OPC_AND,
    OPC_OR,
    OPC_XOR,
    OPC_SHL,
    OPC_SHR,
    OPC_MIN,
    OPC_MAX,
    OPC_MUL,
    OPC_MAC
  } op_e;

  // Any major/func pair not listed maps to OPC_ILL.
  function automatic op_e decode_op(input logic [31:0] instr);
    logic [MAJ_W-1:0]  maj;
    logic [FUNC_W-1:0] fn;
    op_e               op;
    maj = instr[MAJ_LSB +: MAJ_W];
    fn  = instr[FUNC_LSB +: FUNC_W];
    op  = OPC_ILL;
    case (maj)
      OP_ALU: begin
        case (fn)
          F_ADD:   op = OPC_ADD;
          F_SUB:   op = OPC_SUB;
          F_AND:   op = OPC_AND;
          F_OR:    op = OPC_OR;
          F_XOR:   op = OPC_XOR;
          F_SHL:   op = OPC_SHL;
          F_SHR:   op = OPC_SHR;
          F_MIN:   op = OPC_MIN;
          F_MAX:   op = OPC_MAX;
          default: op = OPC_ILL;
        endcase
      end
      OP_MUL: begin
        case (fn)
          F_MUL:   op = OPC_MUL;
          F_MAC:   op = OPC_MAC;
          default: op = OPC_ILL;
        endcase
      end
      default: op = OPC_ILL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pe_lane_alu.sv
// Combinational single-lane ALU/MAC datapath. With PE_CORE_SAT_EN defined,
// ADD/SUB/MAC clamp to the signed lane range and report a sat flag.
module pe_lane_alu
  import pe_core_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  op_e               i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_c,
`ifdef PE_CORE_SAT_EN
  output logic              o_sat,
`endif
  output logic [DATA_W-1:0] o_res
);

  localparam int unsigned PW   = 2 * DATA_W + 1;
  localparam int unsigned SH_W = $clog2(DATA_W);

  logic signed [PW-1:0] w_a;
  logic signed [PW-1:0] w_b;
  logic signed [PW-1:0] w_c;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_wide;
  logic                 w_clampable;
  logic [DATA_W-1:0]    w_res;

  // Wide signed copies keep the full product and MAC sum exact before reduction.
  assign w_a    = PW'($signed(i_a));
  assign w_b    = PW'($signed(i_b));
  assign w_c    = PW'($signed(i_c));
  assign w_prod = w_a * w_b;

  always_comb begin
    w_wide      = '0;
    w_clampable = 1'b0;
    w_res       = '0;
    case (i_op)
      OPC_ADD: begin
        w_wide      = w_a + w_b;
        w_clampable = 1'b1;
        w_res       = w_wide[DATA_W-1:0];
      end
      OPC_SUB: begin
        w_wide      = w_a - w_b;
        w_clampable = 1'b1;
        w_res       = w_wide[DATA_W-1:0];
      end
      OPC_MAC: begin
        w_wide      = w_prod + w_c;
        w_clampable = 1'b1;
        w_res       = w_wide[DATA_W-1:0];
      end
      OPC_MUL: begin
        w_wide = w_prod;
        w_res  = w_wide[DATA_W-1:0];
      end
      OPC_AND: w_res = i_a & i_b;
      OPC_OR:  w_res = i_a | i_b;
      OPC_XOR: w_res = i_a ^ i_b;
      OPC_SHL: w_res = i_a << i_b[SH_W-1:0];
      OPC_SHR: w_res = i_a >> i_b[SH_W-1:0];
      OPC_MIN: w_res = ($signed(i_a) < $signed(i_b)) ? i_a : i_b;
      OPC_MAX: w_res = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;
      default: w_res = '0;
    endcase
  end

`ifdef PE_CORE_SAT_EN
  localparam logic signed [PW-1:0] SMAX = PW'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [PW-1:0] SMIN = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  logic w_over;
  logic w_under;

  assign w_over  = w_clampable && (w_wide > SMAX);
  assign w_under = w_clampable && (w_wide < SMIN);
  assign o_sat   = w_over || w_under;
  assign o_res   = w_over  ? SMAX[DATA_W-1:0] :
                   w_under ? SMIN[DATA_W-1:0] : w_res;
`else
  logic w_unused_wide;
  assign w_unused_wide = ^{w_wide[PW-1:DATA_W], w_clampable};
  assign o_res         = w_res;
`endif

endmodule

// File: rtl/pe_core_multi.sv
// LANES-wide two-stage SIMD ALU/MAC with valid/ready on both sides.
// Optional per-lane saturation and out_sat port under PE_CORE_SAT_EN.
module pe_core_multi
  import pe_core_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr,
  input  logic [LANES*DATA_W-1:0]  op1,
  input  logic [LANES*DATA_W-1:0]  op2,
  input  logic [LANES*DATA_W-1:0]  op3,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*DATA_W-1:0]  out_data,
  output logic [4:0]               out_rd,
  output logic                     out_err,
`ifdef PE_CORE_SAT_EN
  output logic                     out_sat,
`endif
  output logic                     busy,
  output logic [CNT_W-1:0]         retired
);

  localparam int unsigned VW = LANES * DATA_W;

  logic             r_s1_valid;
  op_e              r_s1_op;
  logic [REG_W-1:0] r_s1_rd;
  logic [VW-1:0]    r_s1_a;
  logic [VW-1:0]    r_s1_b;
  logic [VW-1:0]    r_s1_c;
  logic             r_s2_valid;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic             w_out_fire;
  logic [VW-1:0]    w_res;
  logic             w_unused_instr;

  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_out_fire = r_s2_valid && out_ready;
  assign in_ready   = w_s1_adv;
  assign out_valid  = r_s2_valid;
  assign busy       = r_s1_valid || r_s2_valid;

  assign w_unused_instr = ^{instr[31:27], instr[RS1_LSB +: REG_W], instr[RS2_LSB +: REG_W]};

  // S1: decoded op, destination and operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OPC_ILL;
      r_s1_rd    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_c     <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op <= decode_op(instr);
        r_s1_rd <= instr[RD_LSB +: REG_W];
        r_s1_a  <= op1;
        r_s1_b  <= op2;
        r_s1_c  <= op3;
      end
    end
  end

`ifdef PE_CORE_SAT_EN
  logic [LANES-1:0] w_sat;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pe_lane_alu #(
      .DATA_W (DATA_W)
    ) u_alu (
      .i_op  (r_s1_op),
      .i_a   (r_s1_a[g*DATA_W +: DATA_W]),
      .i_b   (r_s1_b[g*DATA_W +: DATA_W]),
      .i_c   (r_s1_c[g*DATA_W +: DATA_W]),
`ifdef PE_CORE_SAT_EN
      .o_sat (w_sat[g]),
`endif
      .o_res (w_res[g*DATA_W +: DATA_W])
    );
  end

  // S2: result register; payload only reloads when a new beat moves in, so it holds under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      out_data   <= '0;
      out_rd     <= '0;
      out_err    <= 1'b0;
`ifdef PE_CORE_SAT_EN
      out_sat    <= 1'b0;
`endif
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_data <= w_res;
        out_rd   <= r_s1_rd;
        out_err  <= (r_s1_op == OPC_ILL);
`ifdef PE_CORE_SAT_EN
        out_sat  <= |w_sat;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if (w_out_fire) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pe_core_multi.sv
// Directed plus randomized bench for pe_core_multi against a longint-arithmetic
// reference model and an in-order expected-result queue.
module tb_pe_core_multi;

  localparam int unsigned LANES  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned VW     = LANES * DATA_W;
  localparam longint      MAXS   = (longint'(1) <<< (DATA_W - 1)) - 1;
  localparam longint      MINS   = -(longint'(1) <<< (DATA_W - 1));

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [VW-1:0]    op1;
  logic [VW-1:0]    op2;
  logic [VW-1:0]    op3;
  logic             out_valid;
  logic             out_ready;
  logic [VW-1:0]    out_data;
  logic [4:0]       out_rd;
  logic             out_err;
`ifdef PE_CORE_SAT_EN
  logic             out_sat;
`endif
  logic             busy;
  logic [CNT_W-1:0] retired;

  pe_core_multi #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .op1       (op1),
    .op2       (op2),
    .op3       (op3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_err   (out_err),
`ifdef PE_CORE_SAT_EN
    .out_sat   (out_sat),
`endif
    .busy      (busy),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] data;
    logic [4:0]    rd;
    logic          err;
    logic          sat;
  } exp_t;

  exp_t             q[$];
  int               checks;
  int               failures;
  logic [CNT_W-1:0] exp_retired;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] maj, input logic [4:0] fn, input logic [4:0] rd);
    return {5'd0, maj, fn, 5'd1, 5'd2, rd};
  endfunction

  function automatic logic [VW-1:0] pk(input logic [31:0] l0, input logic [31:0] l1,
                                       input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Reference: each lane evaluated with 64-bit integer arithmetic, then reduced.
  function automatic exp_t model(input logic [31:0] ins, input logic [VW-1:0] a,
                                 input logic [VW-1:0] b, input logic [VW-1:0] c);
    exp_t       e;
    logic [6:0] maj;
    logic [4:0] fn;
    bit         legal;
    maj   = ins[26:20];
    fn    = ins[19:15];
    legal = (maj == 7'd1 && fn >= 5'd1 && fn <= 5'd9) ||
            (maj == 7'd2 && (fn == 5'd1 || fn == 5'd2));
    e.data = '0;
    e.rd   = ins[4:0];
    e.err  = !legal;
    e.sat  = 1'b0;
    if (legal) begin
      for (int l = 0; l < int'(LANES); l++) begin
        logic [DATA_W-1:0] ua, ub, uc;
        longint            sa, sb, sc, r;
        ua = a[l*DATA_W +: DATA_W];
        ub = b[l*DATA_W +: DATA_W];
        uc = c[l*DATA_W +: DATA_W];
        sa = longint'($signed(ua));
        sb = longint'($signed(ub));
        sc = longint'($signed(uc));
        r  = 0;
        if (maj == 7'd1) begin
          case (fn)
            5'd1: r = sa + sb;
            5'd2: r = sa - sb;
            5'd3: r = longint'(ua & ub);
            5'd4: r = longint'(ua | ub);
            5'd5: r = longint'(ua ^ ub);
            5'd6: r = longint'(ua) << ub[4:0];
            5'd7: r = longint'(ua) >> ub[4:0];
            5'd8: r = (sa < sb) ? sa : sb;
            default: r = (sa > sb) ? sa : sb;
          endcase
        end else if (fn == 5'd1) begin
          r = sa * sb;
        end else begin
          r = sa * sb + sc;
        end
`ifdef PE_CORE_SAT_EN
        if ((maj == 7'd1 && (fn == 5'd1 || fn == 5'd2)) || (maj == 7'd2 && fn == 5'd2)) begin
          if (r > MAXS) begin
            r = MAXS;
            e.sat = 1'b1;
          end else if (r < MINS) begin
            r = MINS;
            e.sat = 1'b1;
          end
        end
`endif
        e.data[l*DATA_W +: DATA_W] = r[DATA_W-1:0];
      end
    end
    return e;
  endfunction

  // One clock: score transfers that happen at the coming edge, then move to the next negedge.
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      exp_retired++;
      if (q.size() == 0) begin
        chk("spurious_out", VW'(out_valid), VW'(1'b0));
      end else begin
        e = q.pop_front();
        chk("sb_data", out_data, e.data);
        chk("sb_rd", VW'(out_rd), VW'(e.rd));
        chk("sb_err", VW'(out_err), VW'(e.err));
`ifdef PE_CORE_SAT_EN
        chk("sb_sat", VW'(out_sat), VW'(e.sat));
`endif
      end
    end
    if (acc) q.push_back(model(instr, op1, op2, op3));
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [VW-1:0] a,
                       input logic [VW-1:0] b, input logic [VW-1:0] c);
    bit acc;
    int n;
    in_valid = 1'b1;
    instr    = ins;
    op1      = a;
    op2      = b;
    op3      = c;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 100) begin
      tick(acc);
      n++;
    end
    if (!acc) chk("issue_timeout", VW'(in_ready), VW'(1'b1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((q.size() > 0 || out_valid) && n < 200) begin
      tick(acc);
      n++;
    end
    chk("drain_left", VW'(q.size()), VW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit            acc;
    logic [VW-1:0] held;
    logic [31:0]   ri;
    logic [6:0]    rmaj;
    checks      = 0;
    failures    = 0;
    exp_retired = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    instr     = '0;
    op1       = '0;
    op2       = '0;
    op3       = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", VW'(out_valid), VW'(1'b0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_rd", VW'(out_rd), VW'(0));
    chk("rst_out_err", VW'(out_err), VW'(1'b0));
    chk("rst_busy", VW'(busy), VW'(1'b0));
    chk("rst_retired", VW'(retired), VW'(0));
`ifdef PE_CORE_SAT_EN
    chk("rst_out_sat", VW'(out_sat), VW'(1'b0));
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", VW'(in_ready), VW'(1'b1));

    // Test 1: ADD latency and values
    issue(mk(7'h01, 5'd1, 5'd5), pk(32'd10, 32'd50, 32'hFFFF_FFFF, 32'd7),
          pk(32'd20, 32'd25, 32'd1, 32'd0), '0);
    chk("t1_not_yet", VW'(out_valid), VW'(1'b0));
    tick(acc);
    chk("t1_valid", VW'(out_valid), VW'(1'b1));
    chk("t1_data", out_data, pk(32'd30, 32'd75, 32'd0, 32'd7));
    chk("t1_rd", VW'(out_rd), VW'(5));
    chk("t1_err", VW'(out_err), VW'(1'b0));
    tick(acc);
    chk("t1_retired", VW'(retired), VW'(1));

    // Test 2: back-to-back SUB, MUL, MAC
    issue(mk(7'h01, 5'd2, 5'd1), pk(32'd9, 32'd0, 32'd100, 32'h8000_0000),
          pk(32'd4, 32'd1, 32'd200, 32'd1), '0);
    issue(mk(7'h02, 5'd1, 5'd2), pk(32'd3, 32'hFFFF_FFFE, 32'h0001_0000, 32'd7),
          pk(32'd5, 32'd6, 32'h0001_0000, 32'hFFFF_FFFF), '0);
    issue(mk(7'h02, 5'd2, 5'd3), pk(32'd3, 32'd3, 32'd3, 32'd3),
          pk(32'd4, 32'd4, 32'd4, 32'd4), pk(32'd5, 32'd5, 32'd5, 32'd5));
    chk("t2_mul_valid", VW'(out_valid), VW'(1'b1));
    tick(acc);
    chk("t2_mac_valid", VW'(out_valid), VW'(1'b1));
    chk("t2_mac_data", out_data, pk(32'd17, 32'd17, 32'd17, 32'd17));
    chk("t2_mac_rd", VW'(out_rd), VW'(3));
    tick(acc);
    chk("t2_empty", VW'(out_valid), VW'(1'b0));

    // Test 3: stall with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = mk(7'h01, 5'd3, 5'd10); op1 = {4{32'hF0F0_1234}}; op2 = {4{32'h0FF0_FF00}};
    tick(acc);
    chk("t3_acc1", VW'(acc), VW'(1'b1));
    instr = mk(7'h01, 5'd6, 5'd11); op1 = {4{32'h0000_0003}}; op2 = {4{32'h0000_0024}};
    tick(acc);
    chk("t3_acc2", VW'(acc), VW'(1'b1));
    instr = mk(7'h01, 5'd9, 5'd12); op1 = {4{32'hFFFF_FFF0}}; op2 = {4{32'h0000_0002}};
    tick(acc);
    chk("t3_acc3_blocked", VW'(acc), VW'(1'b0));
    chk("t3_in_ready_low", VW'(in_ready), VW'(1'b0));
    chk("t3_hold_data", out_data, q[0].data);
    held = out_data;
    repeat (3) tick(acc);
    chk("t3_stable_data", out_data, held);
    chk("t3_stable_rd", VW'(out_rd), VW'(10));
    chk("t3_busy", VW'(busy), VW'(1'b1));
    out_ready = 1'b1;
    tick(acc);
    chk("t3_acc3_after", VW'(acc), VW'(1'b1));
    in_valid = 1'b0;
    drain();

    // Test 4: illegal major opcode
    issue(mk(7'h05, 5'd1, 5'd7), {4{32'h1234_5678}}, {4{32'h1}}, '0);
    tick(acc);
    chk("t4_err", VW'(out_err), VW'(1'b1));
    chk("t4_data_zero", out_data, '0);
    drain();
    chk("t4_retired", VW'(retired), VW'(exp_retired));

    // Test 5: signed overflow on ADD
    issue(mk(7'h01, 5'd1, 5'd9), pk(32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0),
          pk(32'd1, 32'd0, 32'd0, 32'd0), '0);
    tick(acc);
`ifdef PE_CORE_SAT_EN
    chk("t5_sat_data", out_data, pk(32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0));
    chk("t5_out_sat", VW'(out_sat), VW'(1'b1));
`else
    chk("t5_wrap_data", out_data, pk(32'h8000_0000, 32'd0, 32'd0, 32'd0));
`endif
    drain();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      rmaj = (($urandom % 8) < 4) ? 7'h01 : (($urandom % 4) != 0) ? 7'h02 : 7'($urandom);
      ri   = {5'($urandom), rmaj, 5'($urandom % 11), 15'($urandom)};
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      instr = ri;
      for (int l = 0; l < int'(LANES); l++) begin
        op1[l*DATA_W +: DATA_W] = ($urandom % 4 == 0) ? 32'($urandom % 16) : $urandom;
        op2[l*DATA_W +: DATA_W] = ($urandom % 4 == 0) ? 32'($urandom % 16) : $urandom;
        op3[l*DATA_W +: DATA_W] = $urandom;
      end
      tick(acc);
    end
    in_valid = 1'b0;
    drain();
    chk("rand_retired", VW'(retired), VW'(exp_retired));
    chk("rand_idle_busy", VW'(busy), VW'(1'b0));

    // Test 6: reset with two beats in flight
    issue(mk(7'h01, 5'd1, 5'd20), {4{32'd1}}, {4{32'd2}}, '0);
    issue(mk(7'h01, 5'd4, 5'd21), {4{32'd1}}, {4{32'd2}}, '0);
    chk("t6_inflight_busy", VW'(busy), VW'(1'b1));
    rst = 1'b1;
    #1;
    chk("t6_out_valid", VW'(out_valid), VW'(1'b0));
    chk("t6_busy", VW'(busy), VW'(1'b0));
    chk("t6_retired", VW'(retired), VW'(0));
    q.delete();
    exp_retired = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) tick(acc);
    chk("t6_no_output", VW'(out_valid), VW'(1'b0));
    chk("t6_retired_after", VW'(retired), VW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
